correlator_readout_scheduler: RTL and testbench

- Sequences the intensity-correlator datapath.
- Times each integration window and emits integration_clk_pulse so the datapath snapshots and clears its counters.
- Walks the snapshot (NUM_INPUTS channel counts, then NUM_CORRELATORS pair counts) through a read port and serialises each word into bytes for the UART transmitter.
- Sits between the counter bank and the UART TX in the main block, clocked by the PLL clock.

---
 rtl/correlator_readout_scheduler.sv | 149 ++++++++++++++
 tb/tb_correlator_readout_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/correlator_readout_scheduler.sv
// rtl/correlator_readout_scheduler.sv - integration window timer and snapshot-to-UART frame serialiser
module correlator_readout_scheduler #(
  parameter int         NUM_INPUTS      = 12,
  parameter int         NUM_CORRELATORS = NUM_INPUTS*(NUM_INPUTS-1)/2,
  parameter int         RESOLUTION      = 16,
  parameter logic [7:0] HEADER_BYTE     = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [31:0]           period,
  output logic                  integration_clk_pulse,
  output logic                  rd_en,
  output logic [7:0]            rd_addr,
  input  logic [RESOLUTION-1:0] rd_data,
  input  logic                  rd_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  overrun
);

  localparam int NUM_WORDS = NUM_INPUTS + NUM_CORRELATORS;
  localparam int NUM_BYTES = RESOLUTION / 8;

  typedef enum logic [2:0] {IDLE, HEADER, REQ, WAIT, SEND, CHECK} state_t;

  state_t                state;
  logic [31:0]           count;
  logic [31:0]           p_hold;
  logic [7:0]            idx;
  logic [7:0]            byte_cnt;
  logic [RESOLUTION-1:0] word;
  logic [7:0]            checksum;

  logic [31:0] p_floor;
  logic [31:0] p_cur;
  logic        window_end;
  logic        tx_fire;

  // The window length is sampled only at count 0, so a period change lands on the next window.
  always_comb begin
    p_floor    = (period < 32'd2) ? 32'd2 : period;
    p_cur      = (count == 32'd0) ? p_floor : p_hold;
    window_end = (count == p_cur - 32'd1);
    tx_fire    = tx_valid && tx_ready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= IDLE;
      count                 <= 32'd0;
      p_hold                <= 32'd0;
      idx                   <= 8'd0;
      byte_cnt              <= 8'd0;
      word                  <= '0;
      checksum              <= 8'd0;
      integration_clk_pulse <= 1'b0;
      rd_en                 <= 1'b0;
      rd_addr               <= 8'd0;
      tx_data               <= 8'd0;
      tx_valid              <= 1'b0;
      busy                  <= 1'b0;
      overrun               <= 1'b0;
    end else begin
      rd_en <= 1'b0;

      if (!enable) begin
        count                 <= 32'd0;
        integration_clk_pulse <= 1'b0;
        overrun               <= 1'b0;
      end else begin
        if (count == 32'd0) p_hold <= p_floor;
        if (window_end) begin
          count                 <= 32'd0;
          integration_clk_pulse <= 1'b1;
        end else begin
          count                 <= count + 32'd1;
          integration_clk_pulse <= 1'b0;
        end
        if (integration_clk_pulse && state != IDLE) overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (integration_clk_pulse) begin
            state    <= HEADER;
            busy     <= 1'b1;
            checksum <= 8'd0;
            idx      <= 8'd0;
            tx_data  <= HEADER_BYTE;
            tx_valid <= 1'b1;
          end
        end
        HEADER: begin
          if (tx_fire) begin
            tx_valid <= 1'b0;
            rd_en    <= 1'b1;
            rd_addr  <= idx;
            state    <= REQ;
          end
        end
        REQ: state <= WAIT;
        WAIT: begin
          if (rd_valid) begin
            tx_data  <= rd_data[RESOLUTION-1 -: 8];
            word     <= rd_data << 8;
            byte_cnt <= 8'd0;
            tx_valid <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (tx_fire) begin
            checksum <= checksum ^ tx_data;
            if (byte_cnt == 8'(NUM_BYTES - 1)) begin
              if (idx == 8'(NUM_WORDS - 1)) begin
                // tx_valid stays high so the checksum follows back-to-back
                tx_data <= checksum ^ tx_data;
                state   <= CHECK;
              end else begin
                tx_valid <= 1'b0;
                idx      <= idx + 8'd1;
                rd_addr  <= idx + 8'd1;
                rd_en    <= 1'b1;
                state    <= REQ;
              end
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
              tx_data  <= word[RESOLUTION-1 -: 8];
              word     <= word << 8;
            end
          end
        end
        CHECK: begin
          if (tx_fire) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            idx      <= 8'd0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_correlator_readout_scheduler.sv
// tb/tb_correlator_readout_scheduler.sv - randomized self-checking bench for correlator_readout_scheduler
module tb_correlator_readout_scheduler;

  localparam int W         = 6;
  localparam int FRAME_LEN = 2 + W * 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] period = 32'd0;
  logic        integration_clk_pulse;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data = 16'd0;
  logic        rd_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic        overrun;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int base = 0;
  int ncnt = 0;
  int ready_mode = 0;
  int fixed_lat = 2;
  bit spurious = 1'b0;
  int countdown = 0;
  int pend = 0;
  bit prev_hold = 1'b0;
  logic [7:0] prev_data = 8'd0;

  logic [15:0] words [W];
  logic [7:0]  rxq [$];
  int          pq [$];

  correlator_readout_scheduler #(
    .NUM_INPUTS (3),
    .RESOLUTION (16)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .enable                (enable),
    .period                (period),
    .integration_clk_pulse (integration_clk_pulse),
    .rd_en                 (rd_en),
    .rd_addr               (rd_addr),
    .rd_data               (rd_data),
    .rd_valid              (rd_valid),
    .tx_data               (tx_data),
    .tx_valid              (tx_valid),
    .tx_ready              (tx_ready),
    .busy                  (busy),
    .overrun               (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (reset_n) cyc <= cyc + 1;

  always @(negedge clk) if (integration_clk_pulse) pq.push_back(cyc);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Snapshot datapath: answers each read request after a chosen latency.
  always @(negedge clk) begin
    rd_valid = 1'b0;
    if (countdown > 0) begin
      countdown--;
      if (countdown == 0) begin
        rd_valid = 1'b1;
        rd_data  = (pend < W) ? words[pend] : 16'hxxxx;
      end
    end else if (spurious && tx_valid) begin
      rd_valid = 1'b1;
      rd_data  = 16'($urandom);
    end
    if (rd_en) begin
      pend      = int'(rd_addr);
      countdown = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
    end
  end

  // UART sink: collects transferred bytes and checks hold-stability under backpressure.
  always @(negedge clk) begin
    ncnt++;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = (ncnt % 3 == 0);
      2:       tx_ready = 1'b0;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
    if (reset_n) begin
      if (prev_hold) begin
        check("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
        check("tx_hold_data", {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (tx_valid && tx_ready) rxq.push_back(tx_data);
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset(input logic [31:0] p, input logic en);
    reset_n = 1'b0;
    enable  = 1'b0;
    period  = p;
    step(2);
    check("rst_pulse", {31'd0, integration_clk_pulse}, 32'd0);
    check("rst_rd_en", {31'd0, rd_en}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    rxq.delete();
    pq.delete();
    reset_n = 1'b1;
    enable  = en;
    base    = cyc;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (rxq.size() < n && k < budget) begin
      step(1);
      k++;
    end
    check("byte_count", rxq.size(), n);
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int k = 0;
    while (pq.size() < n && k < budget) begin
      step(1);
      k++;
    end
    check("pulse_count", pq.size(), n);
  endtask

  task automatic rand_words();
    for (int i = 0; i < W; i++) words[i] = 16'($urandom);
  endtask

  task automatic compare_frame(input string tag);
    logic [7:0] e [$];
    logic [7:0] x = 8'd0;
    logic [7:0] b;
    e.push_back(8'hA5);
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < 2; j++) begin
        b = words[i][15 - 8*j -: 8];
        e.push_back(b);
        x = x ^ b;
      end
    end
    e.push_back(x);
    wait_bytes(FRAME_LEN, 600);
    for (int i = 0; i < FRAME_LEN; i++)
      check(tag, (i < rxq.size()) ? {24'd0, rxq[i]} : 32'hxxxxxxxx, {24'd0, e[i]});
  endtask

  initial begin
    int k;
    int cnt;

    // Fixed incrementing snapshot, always-ready UART
    for (int i = 0; i < W; i++) words[i] = 16'h0100 + 16'(i);
    ready_mode = 0;
    fixed_lat  = 2;
    do_reset(32'd100, 1'b1);
    wait_pulses(1, 150);
    check("first_pulse_cycle", pq[0] - base, 100);
    step(2);
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    compare_frame("frame_inc");
    check("busy_after_frame", {31'd0, busy}, 32'd0);
    check("tx_valid_after_frame", {31'd0, tx_valid}, 32'd0);
    wait_pulses(2, 150);
    check("second_pulse_cycle", pq[1] - base, 200);

    // Same data, UART ready one cycle in three
    ready_mode = 1;
    do_reset(32'd100, 1'b1);
    compare_frame("frame_throttled");

    // Stalled UART forces overrun; dropping enable clears it and lets the frame drain
    rand_words();
    fixed_lat  = 0;
    ready_mode = 2;
    do_reset(32'd10, 1'b1);
    step(50);
    check("overrun_set", {31'd0, overrun}, 32'd1);
    check("overrun_busy", {31'd0, busy}, 32'd1);
    check("overrun_hold_valid", {31'd0, tx_valid}, 32'd1);
    check("overrun_hold_header", {24'd0, tx_data}, 32'hA5);
    check("overrun_no_bytes", rxq.size(), 0);
    enable     = 1'b0;
    ready_mode = 0;
    step(2);
    check("overrun_cleared", {31'd0, overrun}, 32'd0);
    cnt = pq.size();
    compare_frame("frame_drained");
    step(20);
    check("single_frame_only", rxq.size(), FRAME_LEN);
    check("no_pulse_disabled", pq.size(), cnt);
    check("idle_after_drain", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    k = cyc;
    wait_pulses(cnt + 1, 30);
    check("reenable_pulse_cycle", pq[cnt] - k, 10);

    // Degenerate periods clamp to two cycles
    for (int p = 0; p < 2; p++) begin
      do_reset(32'(p), 1'b1);
      wait_pulses(4, 20);
      check("short_period_first", pq[0] - base, 2);
      for (int i = 1; i < 4; i++) check("short_period_interval", pq[i] - pq[i-1], 2);
    end

    // Period change mid-window applies to the following window
    do_reset(32'd20, 1'b1);
    step(5);
    period = 32'd5;
    wait_pulses(3, 60);
    check("period_change_p0", pq[0] - base, 20);
    check("period_change_p1", pq[1] - base, 25);
    check("period_change_p2", pq[2] - base, 30);

    // Asynchronous reset in the middle of a data word
    rand_words();
    ready_mode = 3;
    do_reset(32'd30, 1'b1);
    k = 0;
    while (!(rxq.size() >= 2 && rxq.size() <= 12 && tx_valid) && k < 300) begin
      step(1);
      k++;
    end
    check("reached_send", {31'd0, k < 300}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("async_rst_rd_en", {31'd0, rd_en}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_pulse", {31'd0, integration_clk_pulse}, 32'd0);
    step(1);
    rxq.delete();
    pq.delete();
    rand_words();
    ready_mode = 1;
    reset_n    = 1'b1;
    base       = cyc;
    wait_pulses(1, 40);
    check("post_rst_pulse_cycle", pq[0] - base, 30);
    compare_frame("frame_after_reset");

    // Random snapshots with spurious rd_valid outside WAIT
    spurious   = 1'b1;
    ready_mode = 3;
    for (int r = 0; r < 3; r++) begin
      rand_words();
      do_reset(32'd40, 1'b1);
      compare_frame("frame_spurious");
    end
    spurious = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
